// File: rtl/ex_iter_ctrl.sv
// ex_iter_ctrl: iteration controller for the e^x range-reduction datapath.
// Takes one unsigned Q4.11 argument, then alternates SEL (the selection stage
// samples the residual) and LOOK (the ln-constant is fetched and subtracted,
// and a step command is issued). It finishes on a zero residual, on a step
// limit, on "below finest constant", or on a constant that exceeds the residual.
//
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   in_valid/in_ready/in_x    argument handshake and argument
//   sel_data                  residual to the selection stage
//   sel_i/sel_int             registered selection result (index, int/frac flag)
//   lut_idx/lut_is_int        constant LUT address; lut_val is its combinational data
//   step_valid/step_i/step_int  one-cycle shift/add step command
//   out_valid/out_ready       result handshake
//   out_steps/out_resid/out_trunc/out_err  result payload
module ex_iter_ctrl #(
   parameter int unsigned DW       = 15,
   parameter int unsigned IW       = 5,
   parameter int unsigned MAX_ITER = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_x,
   output logic [DW-1:0] sel_data,
   input  logic [IW-1:0] sel_i,
   input  logic          sel_int,
   output logic [IW-1:0] lut_idx,
   output logic          lut_is_int,
   input  logic [DW-1:0] lut_val,
   output logic          step_valid,
   output logic [IW-1:0] step_i,
   output logic          step_int,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [4:0]    out_steps,
   output logic [DW-1:0] out_resid,
   output logic          out_trunc,
   output logic          out_err
);

   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      LOOK = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] resid_q, resid_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          trunc_q, trunc_d;
   logic          err_q, err_d;

   logic [CW-1:0] cnt_inc;
   logic [DW-1:0] resid_sub;

   // State and iteration registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         resid_q <= '0;
         cnt_q   <= '0;
         trunc_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         resid_q <= resid_d;
         cnt_q   <= cnt_d;
         trunc_q <= trunc_d;
         err_q   <= err_d;
      end
   end

   // Next-state, iteration update and state-decoded outputs
   always_comb begin
      state_d    = state_q;
      resid_d    = resid_q;
      cnt_d      = cnt_q;
      trunc_d    = trunc_q;
      err_d      = err_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      lut_idx    = '0;
      lut_is_int = 1'b0;
      step_valid = 1'b0;
      step_i     = '0;
      step_int   = 1'b0;
      cnt_inc    = cnt_q + CW'(1);
      resid_sub  = resid_q - lut_val;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               resid_d = in_x;
               cnt_d   = '0;
               trunc_d = 1'b0;
               err_d   = 1'b0;
               state_d = (in_x == '0) ? DONE : SEL;
            end
         end
         SEL: begin
            state_d = LOOK;
         end
         LOOK: begin
            lut_idx    = sel_i;
            lut_is_int = sel_int;
            if (!sel_int && (sel_i == '0)) begin
               // residual below the finest fraction constant
               state_d = DONE;
            end else if (lut_val > resid_q) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               resid_d    = resid_sub;
               cnt_d      = cnt_inc;
               // a step issued during reset would never be matched by a result
               step_valid = rst_n;
               step_i     = sel_i;
               step_int   = sel_int;
               if (resid_sub == '0) begin
                  state_d = DONE;
               end else if (cnt_inc == CW'(MAX_ITER)) begin
                  trunc_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = SEL;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sel_data  = resid_q;
   assign out_steps = cnt_q;
   assign out_resid = resid_q;
   assign out_trunc = trunc_q;
   assign out_err   = err_q;

endmodule

// File: doc/ex_iter_ctrl.md
# ex_iter_ctrl

Iteration controller for the e^x range-reduction datapath. It accepts one 15-bit argument and repeatedly drives the residual into the index-selection stage. For each iteration it fetches the matching ln-constant from the constant LUT, subtracts it from the residual, and issues one shift/add step command to the product datapath. The block sits between the upstream argument source and the selection/LUT/product stages, and reports step count, final residual and status when done.

## Interface
- DW, 15, residual/argument/constant width (Q4.11)
- IW, 5, selection index width
- MAX_ITER, 16, maximum steps per argument (1..31)

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  argument valid
- in_ready  out  1  controller can accept an argument
- in_x  in  DW  argument, unsigned Q4.11
- sel_data  out  DW  residual presented to the selection stage
- sel_i  in  IW  index from the selection stage, registered there, valid 1 cycle after sel_data
- sel_int  in  1  selection path flag: 1 = integer table, 0 = fraction table
- lut_idx  out  IW  constant LUT index (= sel_i)
- lut_is_int  out  1  constant LUT table select (= sel_int)
- lut_val  in  DW  combinational constant for lut_idx/lut_is_int
- step_valid  out  1  one-cycle step command pulse
- step_i  out  IW  step index
- step_int  out  1  step table flag
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_steps  out  5  steps issued
- out_resid  out  DW  final residual
- out_trunc  out  1  MAX_ITER reached with residual nonzero
- out_err  out  1  LUT constant exceeded residual

## Operation
- States: IDLE, SEL, LOOK, DONE.
- IDLE: in_ready=1. On in_valid, latch resid=in_x and clear cnt, trunc and err.
  - If in_x==0, go to DONE.
  - Otherwise go to SEL.
- sel_data is driven continuously from the resid register.
- SEL (1 cycle): the selection stage samples resid. Go to LOOK.
- LOOK (1 cycle): lut_idx=sel_i and lut_is_int=sel_int; lut_val is used in the same cycle. Actions are evaluated in this priority order:
  1. sel_int==0 and sel_i==0: residual is below the finest constant. Go to DONE with no step.
  2. lut_val > resid: set err=1, go to DONE with no step, resid unchanged.
  3. Otherwise: resid <= resid - lut_val (DW-bit unsigned, never negative), pulse step_valid with step_i=sel_i and step_int=sel_int, cnt <= cnt+1.
     - If the new resid==0, go to DONE.
     - Else if cnt+1==MAX_ITER, set trunc=1 and go to DONE.
     - Else go to SEL.
- DONE: out_valid=1, out_steps=cnt, out_resid=resid, out_trunc=trunc, out_err=err. These outputs hold stable until out_ready; on out_ready go to IDLE.
- The step datapath has no back-pressure. It must accept one step per 2 cycles.
- Reset, including mid-iteration: state=IDLE on the next edge, and no further step_valid is issued.

## Timing
- Reset values:
  - in_ready=1 in IDLE after reset.
  - step_valid=0, out_valid=0.
  - out_steps=0, out_resid=0, out_trunc=0, out_err=0.
  - sel_data=0, lut_idx=0, lut_is_int=0, step_i=0, step_int=0.
- Argument accepted at edge T (in_valid & in_ready):
  - SEL occupies cycle T+1.
  - LOOK occupies cycle T+2.
  - The k-th step_valid pulse is in cycle T+2k.
- N steps ending on resid==0 or trunc: out_valid first asserted in cycle T+2N+1.
- Early termination (rule 1 or 2) in the LOOK of iteration N+1: out_valid in cycle T+2N+3.
- in_x==0: out_valid in cycle T+1.
- in_ready=0 in SEL, LOOK and DONE. There is no overlap between arguments.
- out_valid&out_ready at edge D: IDLE in cycle D+1, so the earliest next accept is at edge D+1.
- in_valid asserted in the same cycle as the out_ready handshake is ignored until IDLE.

## Test plan
- Reset for 3 cycles, then release: all outputs at reset values, in_ready=1, no step_valid for 10 idle cycles.
- in_x=1419 (ln2); bench LUT returns 1419 for int index: one step with step_int=1, then out_valid at T+3 with out_steps=1, out_resid=0, trunc=0, err=0.
- in_x=0: out_valid at T+1, out_steps=0, no step_valid.
- in_x=2048; bench selection returns int then fraction indices per a golden LUT model:
  - step pulses occur only on even cycles T+2k;
  - out_resid and out_steps match the model;
  - hold out_ready=0 for 5 cycles and check outputs stay stable.
- Bench LUT returns constant 0 for every index with sel_i!=0: residual never reaches 0, so trunc=1, out_steps=16, out_valid at T+33.
- Bench LUT returns lut_val > resid on the first LOOK: out_err=1, out_steps=0, out_resid=in_x, no step_valid. Separately, assert rst_n=0 in cycle T+4 of a multi-step run: IDLE next edge, and no further step_valid.
